pld_intlv: RTL and testbench
============================

Name: pld_intlv

Overview:
Payload block interleaver for the 802.11a OFDM transmitter, directly downstream of the payload puncturer.
- Consumes the puncturer's bit-serial coded stream, one OFDM symbol (N_CBPS bits) at a time.
- Applies the standard two-step permutation by permuted write into a ping-pong bit buffer.
- Emits the symbol bit-serially in natural read order to the constellation mapper.

Parameters:
NCBPS_MAX, 288, largest coded bits per symbol; sets the depth of each buffer bank.
AW, 9, buffer address width, ceil(log2(NCBPS_MAX)).

Ports:
clk  in  1  single clock for the whole block
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear: drops any partial or buffered symbols and the error flag
di  in  1  coded bit from the puncturer
di_vld  in  1  di is valid this cycle
mode  in  2  0=BPSK(48), 1=QPSK(96), 2=16QAM(192), 3=64QAM(288); sampled on each symbol's first bit
do  out  1  interleaved bit
do_vld  out  1  do is valid
do_rdy  in  1  downstream accepts do this cycle
do_sym_last  out  1  do is the final bit of its symbol
do_mode  out  2  mode of the symbol currently being output
busy  out  1  any bank is being filled, is full, or is draining
err_ovf  out  1  sticky: an input bit was dropped because no bank was free

Behaviour:
- Reset (async) and clr (sync) set the following; both banks become empty:
  - do=0, do_vld=0, do_sym_last=0, do_mode=0, busy=0, err_ovf=0
  - write bank select=0, read bank select=0
- Derived constants per mode:
  - N_CBPS = 48/96/192/288
  - s = 1/1/2/3
  - D = N_CBPS/16 = 3/6/12/18
- Write side:
  - Counters k_lo (0..15) and k_hi (0..D-1). k = 16*k_hi + k_lo counts bits within the symbol.
  - On each accepted di_vld:
    - i = D*k_lo + k_hi. Note floor(16*i/N_CBPS) = k_lo.
    - j = s*floor(i/s) + ((i - k_lo) mod s), computed with non-negative mod.
    - di is written to bank[wsel][j].
  - k_lo increments and wraps at 15, then k_hi increments.
  - When k reaches N_CBPS-1:
    - bank[wsel] is marked full and tagged with the latched mode.
    - wsel toggles and the counters clear.
  - mode is latched when k=0 and di_vld=1. A mode change mid-symbol has no effect until the next symbol.
  - If bank[wsel] is still full or draining when a bit arrives:
    - the bit is dropped and the counters do not advance;
    - err_ovf is set and stays set until rst or clr.
- Read side FSM: IDLE -> RUN -> IDLE.
  - IDLE: when bank[rsel] is full, enter RUN with the read address r=0.
  - RUN:
    - Each cycle with (!do_vld || do_rdy), load do=bank[rsel][r] and set do_vld=1.
    - do_sym_last=1 when r=N_CBPS-1.
    - do_mode is the tag of bank[rsel].
    - After the last bit is loaded, mark the bank empty and toggle rsel.
      - If the other bank is already full, continue directly with r=0 with no bubble.
      - Otherwise return to IDLE.
    - do_vld drops when the last bit is accepted and no new bit is loaded.
  - Output is held stable while do_vld=1 and do_rdy=0.
- Latency: with do_rdy=1, the first output bit is valid on the 2nd rising edge after the edge that samples the symbol's last di.
- Simultaneous events:
  - A bank may be freed by the reader and become the write target in the same cycle; the write wins the following cycle.
  - A write-complete and a read-complete in the same cycle are both honoured.
- Throughput: sustained 1 bit/cycle in and out with no overflow while do_rdy is held high.
- A partial symbol is held indefinitely. Only clr or rst discards it.

Decomposition:
- Shared package (intlv_pkg), holding:
  - mode encodings
  - N_CBPS, s and D lookup functions
  - AW and NCBPS_MAX constants
- One sub-module, intlv_addr: combinational map (k_lo, k_hi, mode) -> j, including the mod-3 path. It is reusable for the signal-field interleaver with mode fixed to BPSK.
- Buffer: 2 x NCBPS_MAX x 1-bit RAM, inferred inside pld_intlv.

Test Plan:
1. BPSK, single 1 at k=1, other 47 bits 0, do_rdy=1 -> exactly one output 1, at output position 3. do_sym_last high on the 48th bit; first do_vld on the 2nd edge after the last di.
2. BPSK input k=16 set -> output position 1. QPSK input k=1 set -> output position 6.
3. 16QAM, impulse at k=1 -> output position 13. 64QAM, impulse at k=1 -> position 20; impulse at k=2 -> position 37.
4. Back-to-back 64QAM symbols at 1 bit/cycle, do_rdy=1, 4 symbols -> 1152 contiguous do_vld bits, matching the golden model. err_ovf=0.
5. do_rdy held 0 through two full 48-bit symbols, then a 3rd symbol's first bit arrives -> that bit is dropped and err_ovf=1. Releasing do_rdy then drains the two stored symbols intact; clr afterwards clears err_ovf.
6. mode changed from 2 to 0 at k=100 of a 16QAM symbol -> that symbol is output as 192 bits with do_mode=2. Async rst mid-drain -> do_vld=0 and busy=0 immediately.

Source files
------------

// File: rtl/intlv_pkg.sv
// Shared definitions for the 802.11a block interleavers: mode encoding,
// buffer geometry and the per-mode constants N_CBPS, s and D.
package intlv_pkg;

   localparam int NCBPS_MAX = 288;
   localparam int AW        = 9;
   // k_hi counts columns of 16 bits, up to D-1 = 17
   localparam int KHW       = 5;

   typedef enum logic [1:0] {
      MODE_BPSK  = 2'd0,
      MODE_QPSK  = 2'd1,
      MODE_16QAM = 2'd2,
      MODE_64QAM = 2'd3
   } mode_t;

   // Coded bits per OFDM symbol
   function automatic logic [AW-1:0] ncbps_of(input logic [1:0] m);
      case (mode_t'(m))
         MODE_BPSK:  return AW'(48);
         MODE_QPSK:  return AW'(96);
         MODE_16QAM: return AW'(192);
         default:    return AW'(288);
      endcase
   endfunction

   // Half the number of bits per subcarrier, at least 1
   function automatic logic [1:0] s_of(input logic [1:0] m);
      case (mode_t'(m))
         MODE_16QAM: return 2'd2;
         MODE_64QAM: return 2'd3;
         default:    return 2'd1;
      endcase
   endfunction

   // Rows of the 16-column interleaver matrix, N_CBPS/16
   function automatic logic [KHW-1:0] d_of(input logic [1:0] m);
      case (mode_t'(m))
         MODE_BPSK:  return KHW'(3);
         MODE_QPSK:  return KHW'(6);
         MODE_16QAM: return KHW'(12);
         default:    return KHW'(18);
      endcase
   endfunction

endpackage

// File: rtl/intlv_addr.sv
// Combinational interleaver address map: input bit position (k_lo, k_hi)
// to output position j. First permutation is the 16-column transpose
// i = D*k_lo + k_hi; the second rotates bits inside each s-bit group.
module intlv_addr
   import intlv_pkg::*;
(
   input  logic [3:0]     k_lo,
   input  logic [KHW-1:0] k_hi,
   input  logic [1:0]     mode,
   output logic [AW-1:0]  j
);

   logic [AW-1:0] d;
   logic [AW-1:0] i;
   logic [1:0]    i_mod3;
   logic [1:0]    klo_mod3;
   logic [1:0]    rot;

   // floor(16*i/N_CBPS) equals k_lo, so the rotation term is (i - k_lo) mod s
   always_comb begin
      d        = AW'(d_of(mode));
      i        = d * AW'(k_lo) + AW'(k_hi);
      i_mod3   = 2'(i % AW'(3));
      klo_mod3 = 2'(k_lo % 4'd3);
      // non-negative (i - k_lo) mod 3; 2-bit wrap keeps the result in 0..2
      rot      = (i_mod3 >= klo_mod3) ? (i_mod3 - klo_mod3)
                                      : (i_mod3 + 2'd3 - klo_mod3);
      case (s_of(mode))
         2'd2:    j = {i[AW-1:1], i[0] ^ k_lo[0]};
         2'd3:    j = i - AW'(i_mod3) + AW'(rot);
         default: j = i;
      endcase
   end

endmodule

// File: rtl/pld_intlv.sv
// Payload block interleaver: permuted write of each symbol into one bank of a
// ping-pong bit buffer, natural-order bit-serial read-out with ready/valid.
module pld_intlv
   import intlv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       di,
   input  logic       di_vld,
   input  logic [1:0] mode,
   output logic       do_bit,
   output logic       do_vld,
   input  logic       do_rdy,
   output logic       do_sym_last,
   output logic [1:0] do_mode,
   output logic       busy,
   output logic       err_ovf
);

   typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

   // Bank select is the address MSB, so both banks share one RAM
   logic mem [0:(2**(AW+1))-1];

   logic [3:0]     k_lo_reg;
   logic [KHW-1:0] k_hi_reg;
   logic           wsel_reg;
   logic [1:0]     wmode_reg;
   logic [1:0]     tag_reg [2];
   logic           err_reg;
   logic [1:0]     occ_reg;
   logic [1:0]     occ_next;
   logic           rsel_reg;
   logic [AW-1:0]  r_reg;
   rd_state_t      rd_state_reg;

   logic           k_first;
   logic [1:0]     eff_mode;
   logic           wr_last;
   logic [AW-1:0]  wr_addr;
   logic           wr_ok;
   logic           wr_en;
   logic           wr_done;
   logic           rd_load;
   logic           rd_last;
   logic           rd_release;
   logic           other_sel;

   // The first bit of a symbol uses the live mode; later bits the latched one
   assign k_first  = (k_lo_reg == 4'd0) && (k_hi_reg == '0);
   assign eff_mode = k_first ? mode : wmode_reg;
   assign wr_last  = (k_lo_reg == 4'd15) && (k_hi_reg == d_of(eff_mode) - KHW'(1));

   intlv_addr u_addr (
      .k_lo (k_lo_reg),
      .k_hi (k_hi_reg),
      .mode (eff_mode),
      .j    (wr_addr)
   );

   assign other_sel  = ~rsel_reg;
   assign rd_load    = (rd_state_reg == RD_RUN) && (!do_vld || do_rdy);
   assign rd_last    = (r_reg == ncbps_of(tag_reg[rsel_reg]) - AW'(1));
   assign rd_release = rd_load && rd_last;

   // A bank whose last bit is being loaded this cycle may take the next
   // symbol's first bit on the same edge; this keeps 1 bit/cycle sustained.
   assign wr_ok   = !occ_reg[wsel_reg] || (rd_release && (rsel_reg == wsel_reg));
   assign wr_en   = di_vld && wr_ok;
   assign wr_done = wr_en && wr_last;

   assign busy    = (|occ_reg) || !k_first || do_vld;
   assign err_ovf = err_reg;

   // Per-bank occupancy: set when its last bit is written, cleared once the
   // reader has loaded its last bit. Both events never target the same bank.
   for (genvar gi = 0; gi < 2; gi++) begin : g_occ
      assign occ_next[gi] = (wr_done && (wsel_reg == 1'(gi)))    ? 1'b1 :
                            (rd_release && (rsel_reg == 1'(gi))) ? 1'b0 :
                            occ_reg[gi];
   end

   // Bank occupancy register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_reg <= '0;
      end else if (clr) begin
         occ_reg <= '0;
      end else begin
         occ_reg <= occ_next;
      end
   end

   // Buffer write port; the RAM itself carries no reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wsel_reg, wr_addr}] <= di;
      end
   end

   // Write-side counters, mode latch, bank tagging and overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_lo_reg   <= '0;
         k_hi_reg   <= '0;
         wsel_reg   <= 1'b0;
         wmode_reg  <= '0;
         tag_reg[0] <= '0;
         tag_reg[1] <= '0;
         err_reg    <= 1'b0;
      end else if (clr) begin
         k_lo_reg   <= '0;
         k_hi_reg   <= '0;
         wsel_reg   <= 1'b0;
         wmode_reg  <= '0;
         tag_reg[0] <= '0;
         tag_reg[1] <= '0;
         err_reg    <= 1'b0;
      end else if (di_vld) begin
         if (wr_ok) begin
            if (k_first) begin
               wmode_reg <= mode;
            end
            if (wr_last) begin
               k_lo_reg          <= '0;
               k_hi_reg          <= '0;
               wsel_reg          <= ~wsel_reg;
               tag_reg[wsel_reg] <= eff_mode;
            end else if (k_lo_reg == 4'd15) begin
               k_lo_reg <= '0;
               k_hi_reg <= k_hi_reg + KHW'(1);
            end else begin
               k_lo_reg <= k_lo_reg + 4'd1;
            end
         end else begin
            err_reg <= 1'b1;
         end
      end
   end

   // Read-side FSM with registered outputs; do_bit is the registered RAM read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_reg <= RD_IDLE;
         rsel_reg     <= 1'b0;
         r_reg        <= '0;
         do_bit       <= 1'b0;
         do_vld       <= 1'b0;
         do_sym_last  <= 1'b0;
         do_mode      <= '0;
      end else if (clr) begin
         rd_state_reg <= RD_IDLE;
         rsel_reg     <= 1'b0;
         r_reg        <= '0;
         do_bit       <= 1'b0;
         do_vld       <= 1'b0;
         do_sym_last  <= 1'b0;
         do_mode      <= '0;
      end else begin
         case (rd_state_reg)
            RD_IDLE: begin
               if (do_vld && do_rdy) begin
                  do_vld      <= 1'b0;
                  do_sym_last <= 1'b0;
               end
               if (occ_reg[rsel_reg]) begin
                  rd_state_reg <= RD_RUN;
                  r_reg        <= '0;
               end
            end
            default: begin
               if (rd_load) begin
                  do_bit      <= mem[{rsel_reg, r_reg}];
                  do_vld      <= 1'b1;
                  do_sym_last <= rd_last;
                  do_mode     <= tag_reg[rsel_reg];
                  if (rd_last) begin
                     rsel_reg <= other_sel;
                     r_reg    <= '0;
                     if (!occ_reg[other_sel]) begin
                        rd_state_reg <= RD_IDLE;
                     end
                  end else begin
                     r_reg <= r_reg + AW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pld_intlv.sv
// Self-checking bench for pld_intlv: directed impulses, back-to-back
// throughput, overflow, mid-symbol mode change, async reset and a
// randomized run, all scored against a formula-level interleaver model.
module tb_pld_intlv;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       di = 1'b0;
   logic       di_vld = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       do_rdy = 1'b0;
   logic       do_bit;
   logic       do_vld;
   logic       do_sym_last;
   logic [1:0] do_mode;
   logic       busy;
   logic       err_ovf;

   typedef struct packed {
      logic       b;
      logic       last;
      logic [1:0] m;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   pending_syms = 0;
   int   rdy_mode = 1;          // 0: low, 1: high, 2: random
   int   cyc = 0;
   int   xfer_cnt = 0;
   int   first_cyc = 0;
   int   last_cyc = 0;
   int   sym_idx = 0;
   int   sym_no = 0;
   int   one_cnt = 0;
   int   one_pos = -1;
   int   last_one_cnt = 0;
   int   last_one_pos = -1;

   pld_intlv dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .di          (di),
      .di_vld      (di_vld),
      .mode        (mode),
      .do_bit      (do_bit),
      .do_vld      (do_vld),
      .do_rdy      (do_rdy),
      .do_sym_last (do_sym_last),
      .do_mode     (do_mode),
      .busy        (busy),
      .err_ovf     (err_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ncb(input logic [1:0] m);
      case (m)
         2'd0:    return 48;
         2'd1:    return 96;
         2'd2:    return 192;
         default: return 288;
      endcase
   endfunction

   // Standard 802.11a two-step permutation written straight from the formulas
   function automatic void model_push(input logic [1:0] m, input logic [287:0] v);
      int n, s, i, j;
      logic [287:0] o;
      n = ncb(m);
      s = (m == 2'd3) ? 3 : ((m == 2'd2) ? 2 : 1);
      o = '0;
      for (int k = 0; k < n; k++) begin
         i = (n / 16) * (k % 16) + k / 16;
         j = s * (i / s) + (i + n - (16 * i) / n) % s;
         o[j] = v[k];
      end
      for (int p = 0; p < n; p++) begin
         exp_q.push_back('{b: o[p], last: (p == n - 1), m: m});
      end
      pending_syms++;
   endfunction

   function automatic logic [287:0] rnd_vec();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Sends one symbol; from bit chg_k on (if >= 0) the mode input shows chg_m
   task automatic send_sym(input logic [1:0] m, input logic [287:0] v,
                           input int gap_pct, input int chg_k, input logic [1:0] chg_m);
      int n;
      n = ncb(m);
      model_push(m, v);
      for (int k = 0; k < n; k++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            di_vld = 1'b0;
            @(posedge clk); #1;
         end
         mode   = (chg_k >= 0 && k >= chg_k) ? chg_m : m;
         di     = v[k];
         di_vld = 1'b1;
         @(posedge clk); #1;
      end
      di_vld = 1'b0;
   endtask

   task automatic wait_drain(input int maxc);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || do_vld) && c < maxc) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   // do_rdy driver
   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       do_rdy = 1'b0;
         1:       do_rdy = 1'b1;
         default: do_rdy = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor / scoreboard, one line per completed symbol
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && do_vld && do_rdy) begin
         xfer_cnt++;
         if (xfer_cnt == 1) first_cyc = cyc;
         last_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("extra_bit", do_vld, 0);
         end else begin
            e = exp_q.pop_front();
            check("do_bit", do_bit, e.b);
            check("do_sym_last", do_sym_last, e.last);
            check("do_mode", do_mode, e.m);
            if (do_bit) begin
               one_cnt++;
               one_pos = sym_idx;
            end
            sym_idx++;
            if (e.last) begin
               $display("sym %0d: mode=%0d bits=%0d ones=%0d", sym_no, e.m, sym_idx, one_cnt);
               last_one_cnt = one_cnt;
               last_one_pos = one_pos;
               one_cnt = 0;
               one_pos = -1;
               sym_idx = 0;
               sym_no++;
               pending_syms--;
            end
         end
      end
   end

   initial begin
      int imp_m[6]   = '{0, 0, 1, 2, 3, 3};
      int imp_k[6]   = '{1, 16, 1, 1, 1, 2};
      int imp_pos[6] = '{3, 1, 6, 13, 20, 37};
      logic [287:0] v;
      int c;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_do_vld", do_vld, 0);
      check("rst_do_bit", do_bit, 0);
      check("rst_sym_last", do_sym_last, 0);
      check("rst_do_mode", do_mode, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_ovf, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Impulses: position and first-output latency
      for (int t = 0; t < 6; t++) begin
         v = '0;
         v[imp_k[t]] = 1'b1;
         send_sym(2'(imp_m[t]), v, 0, -1, 2'd0);
         check("lat_edge0", do_vld, 0);
         @(posedge clk); #1;
         check("lat_edge1", do_vld, 0);
         @(posedge clk); #1;
         check("lat_edge2", do_vld, 1);
         wait_drain(600);
         check("imp_ones", last_one_cnt, 1);
         check("imp_pos", last_one_pos, imp_pos[t]);
      end

      // Four back-to-back 64QAM symbols
      xfer_cnt = 0;
      for (int t = 0; t < 4; t++) send_sym(2'd3, rnd_vec(), 0, -1, 2'd0);
      wait_drain(1000);
      check("b2b_xfers", xfer_cnt, 1152);
      check("b2b_contig", last_cyc - first_cyc + 1, 1152);
      check("b2b_ovf", err_ovf, 0);

      // Overflow with do_rdy held low
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      xfer_cnt = 0;
      send_sym(2'd0, rnd_vec(), 0, -1, 2'd0);
      send_sym(2'd0, rnd_vec(), 0, -1, 2'd0);
      repeat (3) @(posedge clk);
      #1;
      check("ovf_pre", err_ovf, 0);
      check("ovf_busy", busy, 1);
      check("ovf_hold_vld", do_vld, 1);
      di = 1'b1; mode = 2'd0; di_vld = 1'b1;
      @(posedge clk); #1;
      di_vld = 1'b0;
      check("ovf_set", err_ovf, 1);
      rdy_mode = 1;
      wait_drain(500);
      check("ovf_xfers", xfer_cnt, 96);
      check("ovf_sticky", err_ovf, 1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check("clr_err", err_ovf, 0);
      check("clr_busy", busy, 0);

      // Mode change mid-symbol is ignored until the next symbol
      xfer_cnt = 0;
      send_sym(2'd2, rnd_vec(), 0, 100, 2'd0);
      wait_drain(600);
      check("mchg_bits", xfer_cnt, 192);

      // Async reset while draining
      xfer_cnt = 0;
      send_sym(2'd0, rnd_vec(), 0, -1, 2'd0);
      c = 0;
      while (xfer_cnt < 10 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      check("arst_started", xfer_cnt >= 10, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_do_vld", do_vld, 0);
      check("arst_busy", busy, 0);
      exp_q.delete();
      pending_syms = 0;
      sym_idx = 0;
      one_cnt = 0;
      one_pos = -1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("arst_post_vld", do_vld, 0);

      // Randomized modes, data, input gaps and backpressure
      rdy_mode = 2;
      for (int t = 0; t < 8; t++) begin
         c = 0;
         while (pending_syms > 1 && c < 3000) begin
            @(posedge clk); #1;
            c++;
         end
         check("rnd_wait", pending_syms <= 1, 1);
         send_sym(2'($urandom_range(0, 3)), rnd_vec(), 25, -1, 2'd0);
      end
      wait_drain(5000);
      check("rnd_ovf", err_ovf, 0);
      rdy_mode = 1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
